// File: rtl/cam_match_serializer.sv
// Serializes a CAM match vector into a stream of hit indices with count and no-match beat.
// Define MATCH_SER_MSB_FIRST_EN to emit the highest set index first.
module cam_match_serializer #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] match_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic [IDX_W:0]   out_count
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic [IDX_W:0]   count_q;
    logic [IDX_W:0]   count_d;
    logic [IDX_W-1:0] sel_idx;
    logic [WIDTH-1:0] sel_bit;
    logic             one_left;

    always_comb begin
        sel_idx = '0;
        sel_bit = '0;
`ifdef MATCH_SER_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
`endif
            if (pending_q[i]) begin
                sel_idx = IDX_W'(i);
                sel_bit = WIDTH'(1) << i;
            end
        end
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_d = count_d + (IDX_W+1)'(match_vec[i]);
        end
    end

    // At most one bit left; also true for the all-zero single beat.
    assign one_left  = (pending_q & (pending_q - WIDTH'(1))) == '0;
    assign pending_d = pending_q & ~sel_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        pending_q <= match_vec;
                        count_q   <= count_d;
                        state_q   <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        pending_q <= pending_d;
                        if (one_left) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign out_idx   = sel_idx;
    assign out_last  = out_valid && one_left;
    assign out_none  = out_valid && (pending_q == '0);
    assign out_count = count_q;

endmodule

// File: tb/tb_cam_match_serializer.sv
// Directed bench for cam_match_serializer: queue-based beat model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_cam_match_serializer;

    localparam int W  = 16;
    localparam int IW = 4;
`ifdef MATCH_SER_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  match_vec = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          out_none;
    logic [IW:0]   out_count;

    cam_match_serializer #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .match_vec (match_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit last;
        bit none;
    } beat_t;

    beat_t mq[$];
    bit    m_busy  = 1'b0;
    int    m_count = 0;
    int    n_pass  = 0;
    int    n_total = 0;

    // Model: a captured vector becomes a list of beats to be drained in order.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_busy  = 1'b0;
                m_count = 0;
            end else if (!m_busy) begin
                if (in_valid) begin
                    int n;
                    int pushed;
                    beat_t b;
                    n = 0;
                    for (int i = 0; i < W; i++) n += int'(match_vec[i]);
                    pushed = 0;
                    if (n == 0) begin
                        b.idx = 0; b.last = 1'b1; b.none = 1'b1;
                        mq.push_back(b);
                    end else begin
                        for (int k = 0; k < W; k++) begin
                            int i;
                            i = MSB ? (W - 1 - k) : k;
                            if (match_vec[i]) begin
                                pushed++;
                                b.idx = i; b.last = (pushed == n); b.none = 1'b0;
                                mq.push_back(b);
                            end
                        end
                    end
                    m_count = n;
                    m_busy  = 1'b1;
                end
            end else if (out_ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    task automatic cmp_model();
        chk("mdl_in_ready", 32'(in_ready), 32'(!m_busy));
        chk("mdl_out_valid", 32'(out_valid), 32'(m_busy));
        chk("mdl_out_count", 32'(out_count), 32'(m_count));
        if (m_busy) begin
            chk("mdl_out_idx", 32'(out_idx), 32'(mq[0].idx));
            chk("mdl_out_last", 32'(out_last), 32'(mq[0].last));
            chk("mdl_out_none", 32'(out_none), 32'(mq[0].none));
        end
    endtask

    // Advance one edge, then compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cmp_model();
    endtask

    int o8421[4];
    int o0030[2];
    int o00f0[2];

    initial begin
        if (MSB) begin
            o8421 = '{15, 10, 5, 0}; o0030 = '{5, 4}; o00f0 = '{7, 6};
        end else begin
            o8421 = '{0, 5, 10, 15}; o0030 = '{4, 5}; o00f0 = '{4, 5};
        end

        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);

        // all-zero vector
        in_valid = 1'b1; match_vec = 16'h0000; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("zero_valid", 32'(out_valid), 32'd1);
        chk("zero_none", 32'(out_none), 32'd1);
        chk("zero_last", 32'(out_last), 32'd1);
        chk("zero_idx", 32'(out_idx), 32'd0);
        chk("zero_count", 32'(out_count), 32'd0);
        tick();
        chk("zero_in_ready_after", 32'(in_ready), 32'd1);
        chk("zero_valid_after", 32'(out_valid), 32'd0);

        // 8421
        in_valid = 1'b1; match_vec = 16'h8421;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("v8421_idx", 32'(out_idx), 32'(o8421[k]));
            chk("v8421_last", 32'(out_last), 32'(k == 3));
            chk("v8421_count", 32'(out_count), 32'd4);
            tick();
        end
        chk("v8421_done", 32'(out_valid), 32'd0);

        // 0030 with backpressure
        out_ready = 1'b0;
        in_valid = 1'b1; match_vec = 16'h0030;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_idx", 32'(out_idx), 32'(o0030[0]));
            chk("bp_last", 32'(out_last), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        chk("bp_idx0", 32'(out_idx), 32'(o0030[0]));
        tick();
        chk("bp_idx1", 32'(out_idx), 32'(o0030[1]));
        chk("bp_last1", 32'(out_last), 32'd1);
        tick();

        // full vector with ignored mid-burst capture
        in_valid = 1'b1; match_vec = 16'hFFFF;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("full_idx", 32'(out_idx), MSB ? 32'(15 - k) : 32'(k));
            chk("full_last", 32'(out_last), 32'(k == 15));
            chk("full_count", 32'(out_count), 32'd16);
            if (k == 5) begin in_valid = 1'b1; match_vec = 16'h0001; end
            if (k == 6) in_valid = 1'b0;
            tick();
        end
        chk("full_done_valid", 32'(out_valid), 32'd0);
        chk("full_done_ready", 32'(in_ready), 32'd1);
        tick();
        chk("full_no_extra", 32'(out_valid), 32'd0);

        // reset mid-burst
        in_valid = 1'b1; match_vec = 16'h00F0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("mrst_idx", 32'(out_idx), 32'(o00f0[k]));
            chk("mrst_count", 32'(out_count), 32'd4);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_count0", 32'(out_count), 32'd0);
        tick();
        chk("mrst_no_beats", 32'(out_valid), 32'd0);

        // back-to-back vectors with in_valid held
        in_valid = 1'b1; match_vec = 16'h0002;
        tick();
        match_vec = 16'h0004;
        chk("b2b_idx1", 32'(out_idx), 32'd1);
        chk("b2b_last1", 32'(out_last), 32'd1);
        chk("b2b_busy", 32'(in_ready), 32'd0);
        tick();
        chk("b2b_bubble_valid", 32'(out_valid), 32'd0);
        chk("b2b_bubble_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_idx2", 32'(out_idx), 32'd2);
        chk("b2b_last2", 32'(out_last), 32'd1);
        chk("b2b_count2", 32'(out_count), 32'd1);
        tick();
        chk("b2b_end", 32'(out_valid), 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cam_match_serializer.md
Name: cam_match_serializer

Overview:
Downstream stage of the associative-array block. Consumes its 16-bit per-address match vector (bit i set = address i holds the searched content) and converts it into a stream of binary address indices, one per handshake beat, lowest index first. Also reports the total hit count and an explicit no-match beat, so downstream logic never has to decode multi-hot vectors itself.

Parameters:
WIDTH, 16, number of CAM addresses (match vector width); must be a power of two, >= 2
IDX_W, 4, index width; must equal log2(WIDTH)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  match_vec is valid this cycle
in_ready  output  1  block can accept a new match vector
match_vec  input  WIDTH  match vector from the CAM; bit i = hit at address i
out_valid  output  1  out_idx/out_last/out_none/out_count are valid
out_ready  input  1  downstream accepts the current beat
out_idx  output  IDX_W  address index of the current hit
out_last  output  1  current beat is the final beat of this vector
out_none  output  1  captured vector was all-zero; beat carries no address
out_count  output  IDX_W+1  number of set bits in the captured vector (0..WIDTH)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, out_none=0, out_count=0. in_ready=1 from the first cycle after reset is released. Reset overrides all other inputs, including in the middle of a burst: the remaining beats are dropped and out_valid=0 in the next cycle.
- States: IDLE and EMIT.
- IDLE: in_ready=1, out_valid=0. When in_valid=1 at an edge: pending <= match_vec, out_count <= popcount(match_vec), state <= EMIT.
- Latency: a vector captured at edge N produces out_valid=1 in the cycle after edge N.
- EMIT: in_ready=0, and in_valid is ignored (no capture, no error). out_valid=1.
  - pending != 0: out_idx = index of lowest set bit of pending; out_last=1 iff pending has exactly one bit set; out_none=0.
  - pending == 0 (vector was all-zero): single beat with out_idx=0, out_none=1, out_last=1.
- Beat transfer occurs at an edge where out_valid=1 and out_ready=1. On transfer the emitted bit is cleared in pending. If out_last=1, state <= IDLE.
- While out_ready=0, every output holds stable (valid/data must not change until accepted).
- out_count is constant for all beats of one vector. It holds its last value in IDLE until the next capture.
- Throughput: one beat per cycle while out_ready=1. One IDLE bubble cycle separates consecutive vectors: after the last beat transfers at edge M, in_ready=1 in the cycle after M.
- A full vector (all ones) yields exactly WIDTH beats with indices 0..WIDTH-1; out_count=WIDTH, which requires the IDX_W+1 width.
- All outputs are driven from registers or from pending through a priority encoder. There is no combinational path from out_ready or in_valid to any output.

Optional Feature:
Macro MATCH_SER_MSB_FIRST_EN.
- Defined: scan order is reversed. out_idx is the highest set bit of pending, so indices are emitted WIDTH-1 down to 0. The all-zero beat and out_last rules are unchanged.
- Undefined: lowest set bit first, as specified above.

Test Plan:
- Reset, then match_vec=16'h0000 with in_valid=1 -> one beat: out_none=1, out_last=1, out_idx=0, out_count=0; in_ready=1 again in the cycle after the transfer.
- match_vec=16'h8421, out_ready=1 -> beats out_idx 0,5,10,15 on consecutive cycles; out_last only on 15; out_count=4 on every beat. With the macro defined, the order is 15,10,5,0.
- match_vec=16'h0030, out_ready held low for 3 cycles -> out_valid=1 with out_idx=4, out_last=0 stable for all 3 cycles. When out_ready rises: idx 4, then idx 5 with out_last=1.
- match_vec=16'hFFFF -> 16 beats with idx 0..15, out_count=5'd16, out_last only on idx 15. Pulse in_valid=1 with 16'h0001 mid-burst -> ignored, no extra beat.
- Capture 16'h00F0 and accept 2 beats (idx 4,5), then assert rst for one cycle -> out_valid=0 the next cycle, in_ready=1, out_count=0, no further beats.
- Back-to-back: 16'h0002 then 16'h0004 with in_valid held high -> idx 1 (out_last=1), one IDLE bubble, then idx 2 (out_last=1).
